// File: rtl/key_display_pkg.sv
// Shared types and constants for the key display sequencer.
`timescale 1ns/1ps
package key_display_pkg;

  // Display multiplexer states, in the order they are visited.
  typedef enum logic [1:0] {
    SHOW_NEW = 2'd0,
    BLANK_A  = 2'd1,
    SHOW_OLD = 2'd2,
    BLANK_B  = 2'd3
  } mux_state_t;

  // Active-low anode patterns: bit 0 drives the right digit, bit 1 the left.
  localparam logic [1:0] ANODE_OFF   = 2'b11;
  localparam logic [1:0] ANODE_RIGHT = 2'b10;
  localparam logic [1:0] ANODE_LEFT  = 2'b01;

  // One entry of the two-deep key history.
  typedef struct packed {
    logic [3:0] digit;
    logic       vld;
  } hist_entry_t;

  // Width of a counter that must reach the longer of the two dwell limits.
  function automatic int unsigned dwell_width(input int unsigned refresh_div,
                                              input int unsigned blank_cycles);
    int unsigned longest;
    longest = (refresh_div > blank_cycles) ? refresh_div : blank_cycles;
    return $clog2(longest + 1);
  endfunction

  // True for the two slots in which a digit is lit.
  function automatic logic is_show(input mux_state_t st);
    return (st == SHOW_NEW) || (st == SHOW_OLD);
  endfunction

endpackage

// File: rtl/key_display_sequencer_dwell_timer.sv
// Dwell timer: free-running up-counter that is cleared on request and flags
// the last cycle of a slot whose length is supplied at run time.
`timescale 1ns/1ps
module dwell_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] limit,
  output logic             done
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: restart at zero when the owner changes slot, else advance.
  always_comb begin
    count_d = clr ? '0 : count_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Last cycle of the slot; a limit of N gives exactly N cycles per slot.
  assign done = (count_q == limit - 1'b1);

endmodule

// File: rtl/key_display_sequencer.sv
// Key display sequencer: keeps the last two keypad digits and time-multiplexes
// them onto a two-digit common-anode display through one shared decoder, with
// an all-off blanking gap between digit slots to avoid ghosting.
`timescale 1ns/1ps
module key_display_sequencer
  import key_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 1500,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       clear,
  output logic [3:0] seg_digit,
  output logic [1:0] anode_n,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic [7:0] key_count
);

  localparam int unsigned   CNT_W       = dwell_width(REFRESH_DIV, BLANK_CYCLES);
  localparam logic [CNT_W-1:0] SHOW_LIMIT  = CNT_W'(REFRESH_DIV);
  localparam logic [CNT_W-1:0] BLANK_LIMIT = CNT_W'(BLANK_CYCLES);
  localparam bit            HAS_BLANK   = (BLANK_CYCLES != 0);

  // ---------------------------------------------------------------------------
  // Digit history
  // ---------------------------------------------------------------------------
  hist_entry_t new_q, new_d;
  hist_entry_t old_q, old_d;
  logic [7:0]  key_count_q, key_count_d;

  // Next history: clear beats a same-cycle key; a key shifts new into old.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which is what keeps a combinational block from inferring a latch.
    new_d       = new_q;
    old_d       = old_q;
    key_count_d = key_count_q;
    if (clear) begin
      new_d = '0;
      old_d = '0;
    end else if (key_valid) begin
      old_d       = new_q;
      new_d.digit = key_code;
      new_d.vld   = 1'b1;
      key_count_d = key_count_q + 8'd1;
    end
  end

  // History and key counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the history is a handful of flops rather than a RAM, so it is
    // reset like any other state; the display must come up blank and known.
    if (!rst_n) begin
      new_q       <= '0;
      old_q       <= '0;
      key_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      new_q       <= new_d;
      old_q       <= old_d;
      key_count_q <= key_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot timing
  // ---------------------------------------------------------------------------
  mux_state_t       state_q, state_d;
  logic [CNT_W-1:0] dwell_limit;
  logic             dwell_done;
  logic             slot_end;

  // Slot length follows the slot currently being shown.
  always_comb begin
    dwell_limit = is_show(state_q) ? SHOW_LIMIT : BLANK_LIMIT;
  end

  // With no blanking configured a blank state is left on its first cycle, so
  // the only time one is occupied is the single cycle after reset.
  assign slot_end = dwell_done | (!is_show(state_q) & !HAS_BLANK);

  dwell_timer #(
    .WIDTH (CNT_W)
  ) u_dwell_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (slot_end),
    .limit (dwell_limit),
    .done  (dwell_done)
  );

  // Next mux state: advance around the ring at the end of each slot.
  always_comb begin
    state_d = state_q;
    if (slot_end) begin
      unique case (state_q)
        SHOW_NEW: state_d = HAS_BLANK ? BLANK_A : SHOW_OLD;
        BLANK_A:  state_d = SHOW_OLD;
        SHOW_OLD: state_d = HAS_BLANK ? BLANK_B : SHOW_NEW;
        BLANK_B:  state_d = SHOW_NEW;
        default:  state_d = BLANK_B;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Display outputs
  // ---------------------------------------------------------------------------
  logic [3:0] seg_digit_q, seg_digit_d;
  logic [1:0] anode_n_q, anode_n_d;

  // Output decode from the next state and next history, so the display
  // tracks a key landing mid-slot on the same edge the history changes.
  always_comb begin
    seg_digit_d = seg_digit_q;
    anode_n_d   = ANODE_OFF;
    unique case (state_d)
      SHOW_NEW: begin
        seg_digit_d = new_d.digit;
        anode_n_d   = new_d.vld ? ANODE_RIGHT : ANODE_OFF;
      end
      SHOW_OLD: begin
        seg_digit_d = old_d.digit;
        anode_n_d   = old_d.vld ? ANODE_LEFT : ANODE_OFF;
      end
      default: begin
        seg_digit_d = seg_digit_q;
        anode_n_d   = ANODE_OFF;
      end
    endcase
  end

  // Mux FSM with registered, glitch-free segment and anode drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BLANK_B;
      seg_digit_q <= '0;
      anode_n_q   <= ANODE_OFF;
    end else begin
      state_q     <= state_d;
      seg_digit_q <= seg_digit_d;
      anode_n_q   <= anode_n_d;
    end
  end

  assign seg_digit = seg_digit_q;
  assign anode_n   = anode_n_q;
  assign digit_new = new_q.digit;
  assign digit_old = old_q.digit;
  assign key_count = key_count_q;

endmodule

// File: tb/tb_key_display_sequencer.sv
// Self-checking bench for key_display_sequencer (REFRESH_DIV=10, BLANK_CYCLES=2).
`timescale 1ns/1ps
module tb_key_display_sequencer;

  localparam int RD     = 10;
  localparam int BC     = 2;
  localparam int PERIOD = 2 * (RD + BC);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       clear = 1'b0;
  logic [3:0] seg_digit;
  logic [1:0] anode_n;
  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic [7:0] key_count;

  key_display_sequencer #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .clear     (clear),
    .seg_digit (seg_digit),
    .anode_n   (anode_n),
    .digit_new (digit_new),
    .digit_old (digit_old),
    .key_count (key_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: history plus a time-based view of the display ring.
  // ---------------------------------------------------------------------------
  logic [3:0] m_new, m_old, m_seg;
  logic       m_nv, m_ov;
  logic [7:0] m_cnt;
  logic [1:0] m_anode;
  int         m_t;

  logic [3:0] nx_new, nx_old, nx_seg;
  logic       nx_nv, nx_ov;
  logic [7:0] nx_cnt;
  logic [1:0] nx_anode;
  int         nx_t, ph;

  always_comb begin
    nx_new = m_new; nx_old = m_old; nx_nv = m_nv; nx_ov = m_ov; nx_cnt = m_cnt;
    if (clear) begin
      nx_new = 4'h0; nx_old = 4'h0; nx_nv = 1'b0; nx_ov = 1'b0;
    end else if (key_valid) begin
      nx_old = m_new; nx_ov = m_nv; nx_new = key_code; nx_nv = 1'b1;
      nx_cnt = m_cnt + 8'd1;
    end
    nx_t     = m_t + 1;
    ph       = -1;
    nx_anode = 2'b11;
    nx_seg   = m_seg;
    if (nx_t >= BC) begin
      ph = (nx_t - BC) % PERIOD;
      if (ph < RD) begin
        nx_seg   = nx_new;
        nx_anode = nx_nv ? 2'b10 : 2'b11;
      end else if (ph >= RD + BC && ph < 2 * RD + BC) begin
        nx_seg   = nx_old;
        nx_anode = nx_ov ? 2'b01 : 2'b11;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_new <= 4'h0; m_old <= 4'h0; m_nv <= 1'b0; m_ov <= 1'b0; m_cnt <= 8'h00;
      m_t <= 0; m_anode <= 2'b11; m_seg <= 4'h0;
    end else begin
      m_new <= nx_new; m_old <= nx_old; m_nv <= nx_nv; m_ov <= nx_ov; m_cnt <= nx_cnt;
      m_t <= nx_t; m_anode <= nx_anode; m_seg <= nx_seg;
    end
  end

  // Per-cycle display monitor, sampled on the falling edge.
  logic mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("mon_anode_n", 32'(anode_n), 32'(m_anode));
      check("mon_seg_digit", 32'(seg_digit), 32'(m_seg));
      check("mon_one_anode", 32'(anode_n != 2'b00), 32'd1);
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard for history/counter results.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0] nw;
    logic [3:0] od;
    logic [7:0] cnt;
  } exp_t;
  exp_t sb_q[$];

  task automatic sb_pop_check(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_digit_new"}, 32'(digit_new), 32'(e.nw));
      check({tag, "_digit_old"}, 32'(digit_old), 32'(e.od));
      check({tag, "_key_count"}, 32'(key_count), 32'(e.cnt));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: one key event, then an observation window on the anodes.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       kv;
    logic [3:0] code;
    logic       clr;
    int         idle;
    int         exp_r;   // right-anode-low cycles in the window, -1 to skip
    int         exp_l;   // left-anode-low cycles in the window
    logic [3:0] nw;
    logic [3:0] od;
    logic [7:0] cnt;
  } vec_t;
  vec_t vecs[7];

  task automatic apply_vec(input int i);
    exp_t e;
    int   r, l;
    @(negedge clk);
    key_valid = vecs[i].kv;
    key_code  = vecs[i].code;
    clear     = vecs[i].clr;
    e.nw = vecs[i].nw; e.od = vecs[i].od; e.cnt = vecs[i].cnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    clear     = 1'b0;
    sb_pop_check($sformatf("vec%0d", i));
    r = 0;
    l = 0;
    for (int c = 0; c < vecs[i].idle; c++) begin
      @(negedge clk);
      if (anode_n == 2'b10) r++;
      if (anode_n == 2'b01) l++;
    end
    if (vecs[i].exp_r >= 0) begin
      check($sformatf("vec%0d_right_low_cycles", i), 32'(r), 32'(vecs[i].exp_r));
      check($sformatf("vec%0d_left_low_cycles", i), 32'(l), 32'(vecs[i].exp_l));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] prev_code;
    logic [3:0] cur_code;
    logic       found;
    int         lows;
    exp_t       e;

    //            kv    code   clr  idle exp_r exp_l new   old   count
    vecs[0] = '{1'b1, 4'h5, 1'b0, 48,  20,   0, 4'h5, 4'h0, 8'd1};
    vecs[1] = '{1'b1, 4'h3, 1'b0, 40,  -1,   0, 4'h3, 4'h5, 8'd2};
    vecs[2] = '{1'b1, 4'hA, 1'b0, 48,  20,  20, 4'hA, 4'h3, 8'd3};
    vecs[3] = '{1'b1, 4'h7, 1'b1, 30,   0,   0, 4'h0, 4'h0, 8'd3};
    vecs[4] = '{1'b0, 4'hF, 1'b0,  5,  -1,   0, 4'h0, 4'h0, 8'd3};
    vecs[5] = '{1'b1, 4'hC, 1'b0,  0,  -1,   0, 4'hC, 4'h0, 8'd4};
    vecs[6] = '{1'b1, 4'hE, 1'b0, 48,  20,  20, 4'hE, 4'hC, 8'd5};

    // Reset state while rst_n is held low.
    repeat (3) @(negedge clk);
    check("rst_anode_n", 32'(anode_n), 32'h3);
    check("rst_seg_digit", 32'(seg_digit), 32'h0);
    check("rst_digit_new", 32'(digit_new), 32'h0);
    check("rst_digit_old", 32'(digit_old), 32'h0);
    check("rst_key_count", 32'(key_count), 32'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // No keys: display stays dark.
    lows = 0;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      if (anode_n != 2'b11) lows++;
    end
    check("idle_anode_low_cycles", 32'(lows), 32'd0);
    check("idle_key_count", 32'(key_count), 32'd0);

    for (int i = 0; i < 7; i++) apply_vec(i);

    // 256 back-to-back keys from a fresh reset: counter wraps to zero.
    do_reset();
    prev_code = 4'h0;
    cur_code  = 4'h0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      prev_code = cur_code;
      cur_code  = 4'(i * 7 + 3);
      key_valid = 1'b1;
      key_code  = cur_code;
      e.nw = cur_code; e.od = prev_code; e.cnt = 8'(i + 1);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      sb_pop_check("burst");
    end
    key_valid = 1'b0;
    check("burst_final_count", 32'(key_count), 32'h00);
    check("burst_final_new", 32'(digit_new), 32'(cur_code));
    check("burst_final_old", 32'(digit_old), 32'(prev_code));

    // Asynchronous reset in the middle of a SHOW_OLD slot.
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (anode_n == 2'b01) found = 1'b1;
    end
    check("found_show_old", 32'(found), 32'd1);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_anode_n", 32'(anode_n), 32'h3);
    check("async_rst_digit_new", 32'(digit_new), 32'h0);
    check("async_rst_digit_old", 32'(digit_old), 32'h0);
    check("async_rst_seg_digit", 32'(seg_digit), 32'h0);
    check("async_rst_key_count", 32'(key_count), 32'h0);
    sb_q.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'h9;
    e.nw = 4'h9; e.od = 4'h0; e.cnt = 8'd1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    sb_pop_check("post_rst_key");
    check("post_rst_cycle1_anode_n", 32'(anode_n), 32'h3);
    @(posedge clk);
    #1;
    check("post_rst_cycle2_anode_n", 32'(anode_n), 32'h2);
    check("post_rst_cycle2_seg_digit", 32'(seg_digit), 32'h9);

    repeat (30) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_display_sequencer.md
Name: key_display_sequencer

Overview:
Controller that sits between the keypad scanner and a two-digit, common-anode seven-segment display. It captures debounced key events into a two-entry digit history: the newest key goes on the right digit and the previous key shifts to the left digit. It time-multiplexes one shared seven-segment decoder between the two digits. A blanking interval between digits prevents ghosting.

Parameters:
REFRESH_DIV, 1500, clk cycles each digit is shown per refresh slot (about 1 kHz per digit at 3 MHz); legal range ≥2.
BLANK_CYCLES, 8, clk cycles with both anodes off between digit slots; 0 means no blank states.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
key_valid  in  1  single-cycle pulse; key_code is valid this cycle
key_code  in  4  hex key value 0x0-0xF
clear  in  1  synchronous clear of the digit history
seg_digit  out  4  hex value presented to the shared seven-segment decoder
anode_n  out  2  active-low anode enables; [0]=right (new) digit, [1]=left (old) digit
digit_new  out  4  most recent key
digit_old  out  4  previous key
key_count  out  8  number of accepted keys; wraps 0xFF->0x00

Behaviour:
- Reset values: digit_new=0, digit_old=0, new_vld=0, old_vld=0, key_count=0, seg_digit=0, anode_n=2'b11, state=BLANK_B, dwell counter=0.
- History update:
  - On a cycle with key_valid=1 and clear=0: digit_old<=digit_new, old_vld<=new_vld, digit_new<=key_code, new_vld<=1, key_count<=key_count+1 (mod 256).
  - The update is visible on the next edge, so latency is 1 cycle.
- clear=1: digit_new=0, digit_old=0, both valid flags=0; key_count is unchanged. If clear and key_valid occur in the same cycle, clear wins and the key is dropped.
- Back-to-back key_valid pulses on consecutive cycles are each accepted. No pulses are lost, and there is no backpressure.
- Mux FSM cycle: SHOW_NEW -> BLANK_A -> SHOW_OLD -> BLANK_B -> SHOW_NEW.
- Dwell counter:
  - Width is $clog2(max(REFRESH_DIV, BLANK_CYCLES)+1).
  - Cleared on every state change, incremented otherwise.
  - A state exits when counter == dwell-1. SHOW states dwell exactly REFRESH_DIV cycles; BLANK states dwell exactly BLANK_CYCLES cycles.
- If BLANK_CYCLES==0, the BLANK states are never entered: SHOW_NEW <-> SHOW_OLD directly.
- Full period is 2*(REFRESH_DIV+BLANK_CYCLES) cycles.
- After reset release, anodes stay off for BLANK_CYCLES cycles (0 if BLANK_CYCLES==0), then SHOW_NEW is entered.
- Registered outputs: seg_digit and anode_n are flops loaded from next-state decode, so they change on the same edge the state changes and are glitch-free.
  - SHOW_NEW: seg_digit=digit_new, anode_n=new_vld ? 2'b10 : 2'b11.
  - SHOW_OLD: seg_digit=digit_old, anode_n=old_vld ? 2'b01 : 2'b11.
  - BLANK states: anode_n=2'b11 and seg_digit holds its last value.
- A key arriving mid-slot updates seg_digit on the next edge only if the current slot shows the changed digit. The slot timing is not restarted.
- Never more than one anode is low in any cycle.
- Asserting rst_n low mid-operation returns all state to the reset values asynchronously, with anodes off immediately.

Decomposition:
- Package key_display_pkg holds:
  - typedef enum logic [1:0] mux_state_t {SHOW_NEW, BLANK_A, SHOW_OLD, BLANK_B}
  - constants ANODE_OFF=2'b11, ANODE_RIGHT=2'b10, ANODE_LEFT=2'b01
- One sub-module, dwell_timer: parameterised counter with a clear input and a done = (count == limit-1) output, where the limit is a run-time input. Instantiated once; its limit is selected from the current state.

Test Plan (bench params REFRESH_DIV=10, BLANK_CYCLES=2):
- Reset release, no keys -> anode_n=2'b11 for 48+ cycles; state cycles with period 24; key_count=0.
- key_valid with key_code=0x5 -> next cycle digit_new=5, digit_old=0, key_count=1; right anode low 10 of every 24 cycles, left anode never low.
- Keys 0x3 then 0xA, 40 cycles apart -> digit_new=A, digit_old=3. During SHOW_OLD, seg_digit=3 and anode_n=01; during SHOW_NEW, seg_digit=A and anode_n=10; a 2-cycle 11 gap sits between every slot.
- clear and key_valid (0x7) in the same cycle -> both digits 0, both anodes off, key_count unchanged.
- 256 key pulses back-to-back -> key_count wraps to 0x00; final digit_new and digit_old equal the last two codes sent.
- Assert rst_n mid-SHOW_OLD -> anode_n=11 and digits=0 immediately (asynchronous). After release, the first anode-low cycle occurs exactly 2 cycles later, and only if a key is received.
